// File: rtl/cache2vias_ctrl.sv
// cache2vias_ctrl: 2-way 8-set write-back/write-allocate LRU cache; cpu_* request/ack port, mem_* req/ack write-back and refill port
module cache2vias_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              hit,
  output logic              miss,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  localparam int TW = ADDR_W - 3;
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;
  state_t state_q, state_d;
  logic [1:0] valid [8];
  logic [1:0] dirty [8];
  logic [TW-1:0] tags [8][2];
  logic [DATA_W-1:0] data [8][2];
  logic [7:0] lru;
  logic [ADDR_W-1:0] a_addr;
  logic a_we;
  logic [DATA_W-1:0] a_wdata;
  logic vway;
  logic [2:0] idx;
  logic [TW-1:0] tg;
  logic h0, h1, hit_any, hw, vic, vic_dirty;
  always_comb begin
    idx = a_addr[2:0];
    tg = a_addr[ADDR_W-1:3];
    h0 = valid[idx][0] && tags[idx][0] == tg;
    h1 = valid[idx][1] && tags[idx][1] == tg;
    hit_any = h0 || h1;
    hw = h1;
    vic = !valid[idx][0] ? 1'b0 : !valid[idx][1] ? 1'b1 : lru[idx];
    vic_dirty = valid[idx][vic] && dirty[idx][vic];
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = cpu_req && !cpu_ack ? LOOKUP : IDLE;
      LOOKUP:    state_d = hit_any ? IDLE : vic_dirty ? WRITEBACK : REFILL;
      WRITEBACK: state_d = mem_ack ? REFILL : WRITEBACK;
      REFILL:    state_d = mem_req && mem_ack ? RESPOND : REFILL;
      RESPOND:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) state_q <= !resetn ? IDLE : state_d;
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) begin
        valid[i] <= '0;
        dirty[i] <= '0;
      end
      lru <= '0;
      cpu_ack <= 1'b0;
      hit <= 1'b0;
      miss <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      cpu_rdata <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      hit <= 1'b0;
      miss <= 1'b0;
      case (state_q)
        IDLE: if (cpu_req && !cpu_ack) begin
          a_addr <= cpu_addr;
          a_we <= cpu_we;
          a_wdata <= cpu_wdata;
        end
        LOOKUP: if (hit_any) begin
          cpu_ack <= 1'b1;
          hit <= 1'b1;
          lru[idx] <= ~hw;
          cpu_rdata <= a_we ? a_wdata : data[idx][hw];
          if (a_we) begin
            data[idx][hw] <= a_wdata;
            dirty[idx][hw] <= 1'b1;
          end
        end else begin
          vway <= vic;
          mem_req <= 1'b1;
          mem_we <= vic_dirty;
          mem_addr <= vic_dirty ? {tags[idx][vic], idx} : a_addr;
          mem_wdata <= data[idx][vic];
        end
        WRITEBACK: if (mem_ack) mem_req <= 1'b0;
        // mem_req low on entry means we came from a write-back: that cycle is the mandatory gap
        REFILL: if (!mem_req) begin
          mem_req <= 1'b1;
          mem_we <= 1'b0;
          mem_addr <= a_addr;
        end else if (mem_ack) begin
          mem_req <= 1'b0;
          valid[idx][vway] <= 1'b1;
          dirty[idx][vway] <= a_we;
          tags[idx][vway] <= tg;
          data[idx][vway] <= a_we ? a_wdata : mem_rdata;
          lru[idx] <= ~vway;
          cpu_ack <= 1'b1;
          miss <= 1'b1;
          cpu_rdata <= a_we ? a_wdata : mem_rdata;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/cache2vias_ctrl.md
# cache2vias_ctrl

Two-way set-associative cache controller with write-back, write-allocate and per-set LRU replacement. It owns the tag/data arrays (8 sets × 2 ways) and sits between the processor request port and main memory. It handles the memory-facing end of the cache: victim selection, dirty write-back and line refill. Hits complete without memory traffic; misses issue one optional write-back followed by one refill over a req/ack memory handshake.

## Interface
- ADDR_W, 5, address width; tag = addr[4:3], index = addr[2:0]
- DATA_W, 8, data word width; one word per line
- clock  in  1  single clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- cpu_req  in  1  request strobe, sampled only in IDLE with cpu_ack low
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  5  request address
- cpu_wdata  in  8  write data
- cpu_rdata  out  8  read data (for writes, the written word); valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- hit  out  1  pulses with cpu_ack when the access hit
- miss  out  1  pulses with cpu_ack when the access missed
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  1 = write-back, 0 = refill read
- mem_addr  out  5  memory word address
- mem_wdata  out  8  write-back data
- mem_rdata  in  8  refill data; valid when mem_ack=1
- mem_ack  in  1  memory completion; ignored unless mem_req=1

## Operation
- Per-way, per-set state: valid, dirty, tag[1:0], data[7:0]. Per-set state: lru bit, which names the victim way.
- The FSM has five states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- **IDLE:** when cpu_req=1 and cpu_ack=0, latch addr, we and wdata, then go to LOOKUP.
- **LOOKUP:** a way hits when valid=1 and its tag equals addr[4:3].
  - On a hit: a read returns that way's data. A write stores wdata and sets dirty=1.
  - On a miss: select the victim. Take way0 if it is invalid, else way1 if it is invalid, else way[lru].
  - After a miss, go to WRITEBACK if the victim is valid and dirty; otherwise go to REFILL.
- **WRITEBACK:** drive mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim data. On mem_ack, go to REFILL.
- **REFILL:** drive mem_req=1, mem_we=0, mem_addr=latched addr. On mem_ack, load the victim:
  - data=mem_rdata, tag=addr[4:3], valid=1, dirty=0.
  - For a write, the stored data is wdata instead, with dirty=1.
  - Then go to RESPOND.
- **RESPOND:** the miss completion path; drives cpu_ack and miss, then returns to IDLE.
- On every completed access, lru[index] is set to the way *not* accessed.
- cpu_rdata holds its last value outside ack cycles.

## Timing
- Reset (resetn=0 at a rising edge) sets: state=IDLE, all valid/dirty/lru=0, and cpu_ack, hit, miss, mem_req, mem_we, cpu_rdata, mem_addr, mem_wdata all 0.
- All outputs are registered.
- **Hit latency:** request seen at edge E0, LOOKUP, then cpu_ack=hit=1 in the cycle after edge E1. That is 2 cycles from cpu_req assertion to ack.
- **Miss, clean victim:** mem_req rises after edge E1. cpu_ack=miss=1 in the cycle after the edge that samples mem_ack.
- **Miss, dirty victim:** the write-back must complete before the refill starts. mem_req drops for exactly 1 cycle between the two transactions.
- mem_req falls on the edge that samples mem_ack=1. mem_addr, mem_we and mem_wdata are stable for the whole time mem_req=1.
- The requester holds cpu_addr, cpu_we and cpu_wdata until cpu_ack. cpu_req still high during the ack cycle is not accepted; it is accepted on the following cycle.
- hit and miss are never both 1. Each is 0 whenever cpu_ack=0.
- **Reset mid-transaction:** an outstanding memory transaction is abandoned. mem_req=0 after the reset edge, and the line is not installed.

## Test plan
Bench memory responds with a random 1–4 cycle mem_ack latency.
- **Cold read miss:** reset; read 0x0A with mem[0x0A]=0x3C → one refill read at addr 0x0A, no write-back, cpu_rdata=0x3C, miss=1.
- **Repeat read hit:** read 0x0A again → hit=1, cpu_ack 2 cycles after cpu_req, mem_req stays 0.
- **LRU, clean eviction:** read 0x02, 0x0A, 0x02, then 0x12 (all set 2) → 0x0A's way is replaced with no mem_we=1 cycle; a later read of 0x02 hits.
- **Dirty write-back:** write 0x02←0xA5 (hit), read 0x12, then read 0x1A → write-back mem_we=1, mem_addr=0x02, mem_wdata=0xA5, then refill read at 0x1A, then miss=1.
- **Write-allocate:** after reset, write 0x07←0x55 → refill read at 0x07, ack with miss=1 and cpu_rdata=0x55; a later read of 0x07 hits and returns 0x55.
- **Reset during refill:** assert resetn=0 during REFILL before mem_ack → mem_req=0 and all outputs 0 after the reset edge; a later read of the same addr misses again.
